// File: rtl/aes_pkg.sv
// Shared definitions for the AES stream controller slice.
// Holds state encoding, constants and the AES round functions.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] blk_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] OUT    = 2'd2;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam blk_t SCRUB_VAL = 128'h1;
    localparam blk_t AES_DEFAULT_KEY =
        128'h5468617473206d79204b756e67204675;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Field inverse as a^254; maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] x,
        input int         n
    );
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3)
                 ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic blk_t sub_bytes(input blk_t s, input logic inv);
        blk_t o;
        o = s;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8])
                                  : sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4 of the state.
    function automatic blk_t shift_rows(input blk_t s, input logic inv);
        blk_t o;
        int   src;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s, input logic inv);
        blk_t       o;
        logic [7:0] m [4];
        logic [7:0] acc;
        o = s;
        if (inv) begin
            m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
        end else begin
            m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(m[(j - r + 4) % 4],
                                     s[127-8*(4*c+j) -: 8]);
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic blk_t next_key(
        input blk_t       k,
        input logic [7:0] rc
    );
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {k[23:0], k[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]),
              sbox(t[15:8]), sbox(t[7:0])};
        t  = t ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic blk_t aes_encrypt(input blk_t pt, input blk_t key);
        blk_t       s;
        blk_t       k;
        logic [7:0] rc;
        s  = pt ^ key;
        k  = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = next_key(k, rc);
            rc = xtime(rc);
            s  = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < 10) s = mix_columns(s, 1'b0);
            s = s ^ k;
        end
        return s;
    endfunction

    function automatic blk_t aes_decrypt(input blk_t ct, input blk_t key);
        blk_t       s;
        blk_t       ks [11];
        logic [7:0] rc;
        ks[0] = key;
        rc    = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            ks[r] = next_key(ks[r-1], rc);
            rc    = xtime(rc);
        end
        s = ct ^ ks[10];
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[r];
            if (r > 0) s = mix_columns(s, 1'b1);
        end
        return s;
    endfunction

endpackage

// File: rtl/aes_core_sel.sv
// Combinational AES-128 cores and the mode mux feeding the controller.
// The cores only ever see the op registers, never live inputs.
module encrypter
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] in_blk,
    input  logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] out_blk
);
    assign out_blk = aes_encrypt(in_blk, key);
endmodule

module decrypter
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] in_blk,
    input  logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] out_blk
);
    assign out_blk = aes_decrypt(in_blk, key);
endmodule

module aes_core_sel
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] op_data,
    input  logic [AES_BLK_W-1:0] op_key,
    input  logic                 op_mode,
    output logic [AES_BLK_W-1:0] result
);
    logic [AES_BLK_W-1:0] enc_res;
    logic [AES_BLK_W-1:0] dec_res;

    encrypter u_enc (
        .in_blk  (op_data),
        .key     (op_key),
        .out_blk (enc_res)
    );

    decrypter u_dec (
        .in_blk  (op_data),
        .key     (op_key),
        .out_blk (dec_res)
    );

    // Pick the core matching the latched block mode.
    always_comb begin
        result = (op_mode == MODE_DEC) ? dec_res : enc_res;
    end
endmodule

// File: rtl/aes_stream_ctrl.sv
// Block-at-a-time AES sequencer: accept, settle, present, scrub.
// Run-time key, per-block mode, programmable settle and scrub times.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter logic [127:0] DEFAULT_KEY   = AES_DEFAULT_KEY,
    parameter int           SETTLE_CYCLES = 1656303,
    parameter int           SCRUB_CYCLES  = 2666752,
    parameter int           CNT_W         = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         key_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode
);
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'(SETTLE_CYCLES - 1);
    localparam bit SCRUB_EN = (SCRUB_CYCLES > 0);
    localparam logic [CNT_W-1:0] SCRUB_LAST =
        CNT_W'(SCRUB_EN ? SCRUB_CYCLES - 1 : 0);

    logic [1:0]   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] op_data_q, op_data_d;
    logic [127:0] op_key_q, op_key_d;
    logic         op_mode_q, op_mode_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_mode_q, out_mode_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] core_res;

    aes_core_sel u_core (
        .op_data (op_data_q),
        .op_key  (op_key_q),
        .op_mode (op_mode_q),
        .result  (core_res)
    );

    assign in_ready  = (state_q == IDLE);
    assign key_err   = key_load && (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

    // Next-state logic for the accept/settle/present sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        op_data_d   = op_data_q;
        op_key_d    = op_key_q;
        op_mode_d   = op_mode_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (key_load) key_d = key_in;
                if (in_valid) begin
                    op_data_d = in_data;
                    op_mode_d = in_mode;
                    op_key_d  = key_load ? key_in : key_q;
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end else if (SCRUB_EN) begin
                    if (cnt_q == SCRUB_LAST) begin
                        out_data_d = SCRUB_VAL;
                        out_mode_d = MODE_ENC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    out_data_d  = core_res;
                    out_mode_d  = op_mode_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, key, op and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_q       <= DEFAULT_KEY;
            op_data_q   <= '0;
            op_key_q    <= '0;
            op_mode_q   <= MODE_ENC;
            out_data_q  <= SCRUB_VAL;
            out_mode_q  <= MODE_ENC;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            op_data_q   <= op_data_d;
            op_key_q    <= op_key_d;
            op_mode_q   <= op_mode_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
